// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fixed-priority arbiter that shares one single-port memory
//               between an instruction-fetch port and a data port. The data
//               port wins ties. Each access holds the memory for MEM_LAT
//               cycles and then spends one DONE cycle pulsing the winner's
//               done output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_done,
   output logic [15:0] i_rdata,
   // data port
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   // shared memory
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   input  logic [15:0] mem_data_out,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // The counter counts down from MEM_LAT-1 to 0, so ACCESS lasts MEM_LAT cycles.
   localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

   state_t      state_q,     state_d;
   logic [3:0]  cnt_q,       cnt_d;
   logic [15:0] addr_q,      addr_d;
   logic        wr_q,        wr_d;
   logic [15:0] wdata_q,     wdata_d;
   logic        gnt_data_q,  gnt_data_d;   // 1 = data port owns the access
   logic [15:0] i_rdata_q,   i_rdata_d;
   logic [15:0] d_rdata_q,   d_rdata_d;

   // State register and latched access fields; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= 16'd0;
         wr_q       <= 1'b0;
         wdata_q    <= 16'd0;
         gnt_data_q <= 1'b0;
         i_rdata_q  <= 16'd0;
         d_rdata_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         gnt_data_q <= gnt_data_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Next-state logic: grant in IDLE, time the access, capture read data.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      gnt_data_d = gnt_data_q;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (d_req) begin
               state_d    = ST_ACCESS;
               cnt_d      = LAT_INIT;
               addr_d     = d_addr;
               wr_d       = d_wr;
               wdata_d    = d_wdata;
               gnt_data_d = 1'b1;
            end else if (i_req) begin
               state_d    = ST_ACCESS;
               cnt_d      = LAT_INIT;
               addr_d     = i_addr;
               wr_d       = 1'b0;
               wdata_d    = 16'd0;
               gnt_data_d = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               // Memory read data is valid in the final access cycle only.
               if (!wr_q) begin
                  if (gnt_data_q) begin
                     d_rdata_d = mem_data_out;
                  end else begin
                     i_rdata_d = mem_data_out;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are forced low while rst is asserted so reset is visible immediately.
   logic in_access;
   logic in_done;
   assign in_access   = (state_q == ST_ACCESS) && !rst;
   assign in_done     = (state_q == ST_DONE) && !rst;

   assign mem_enable  = in_access;
   assign mem_wr      = in_access && wr_q;
   assign mem_addr    = in_access ? addr_q  : 16'd0;
   assign mem_data_in = in_access ? wdata_q : 16'd0;
   assign i_done      = in_done && !gnt_data_q;
   assign d_done      = in_done && gnt_data_q;
   assign i_rdata     = rst ? 16'd0 : i_rdata_q;
   assign d_rdata     = rst ? 16'd0 : d_rdata_q;
   assign busy        = (state_q != ST_IDLE) && !rst;

endmodule
`default_nettype wire
